store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 172 +++++++++++++++++
 tb/tb_store_buffer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of retired stores waiting to drain into the
// data cache, with combinational store-to-load forwarding for load probes.
`ifndef STORE_BUFFER_ENTRIES
`define STORE_BUFFER_ENTRIES 4
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef SIZE_WRITE_WIDTH
`define SIZE_WRITE_WIDTH 2
`endif
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'd0
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'd2
`endif

module store_buffer #(
    parameter int SB_ENTRIES       = `STORE_BUFFER_ENTRIES,
    parameter int WORD_SIZE        = `WORD_SIZE,
    parameter int SIZE_WRITE_WIDTH = `SIZE_WRITE_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WORD_SIZE-1:0]        in_addr,
    input  logic [WORD_SIZE-1:0]        in_value,
    input  logic [SIZE_WRITE_WIDTH-1:0] in_size,
    output logic                        full,
    output logic                        empty,
    output logic [WORD_SIZE-1:0]        sb_addr,
    output logic [WORD_SIZE-1:0]        sb_value,
    output logic [SIZE_WRITE_WIDTH-1:0] sb_size,
    output logic                        wenable,
    input  logic                        store_success,
    input  logic                        ld_valid,
    input  logic [WORD_SIZE-1:0]        ld_addr,
    input  logic [SIZE_WRITE_WIDTH-1:0] ld_size,
    output logic                        fwd_hit,
    output logic [WORD_SIZE-1:0]        fwd_data,
    output logic                        fwd_stall
);

    localparam int PTR_W = $clog2(SB_ENTRIES);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [SIZE_WRITE_WIDTH-1:0] SZ_WORD = SIZE_WRITE_WIDTH'(`FULL_WORD_SIZE);

    logic [WORD_SIZE-1:0]        addr_q  [SB_ENTRIES];
    logic [WORD_SIZE-1:0]        value_q [SB_ENTRIES];
    logic [SIZE_WRITE_WIDTH-1:0] size_q  [SB_ENTRIES];
    logic [SB_ENTRIES-1:0]       valid_q, valid_d;
    logic [PTR_W-1:0]            head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]            count_q, count_d;

    logic                        push, pop;

    logic [PTR_W-1:0]            scan_idx, sel_idx;
    logic                        sel_found, sel_word, ld_word, ent_word;
    logic [7:0]                  sel_byte;

    assign full    = (count_q == CNT_W'(SB_ENTRIES));
    assign empty   = (count_q == '0);
    assign wenable = !empty;
    assign push    = in_valid && !full;
    assign pop     = wenable && store_success;

    // Head entry offered to the cache; zeroed when nothing is pending.
    always_comb begin
        sb_addr  = '0;
        sb_value = '0;
        sb_size  = '0;
        if (!empty) begin
            sb_addr  = addr_q[head_q];
            sb_value = value_q[head_q];
            sb_size  = size_q[head_q];
        end
    end

    // Next-state for pointers, count and occupancy bits.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        valid_d = valid_q;
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards every pending entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    // Entry payload; guarded by the valid bits so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail_q]  <= in_addr;
            value_q[tail_q] <= in_value;
            size_q[tail_q]  <= in_size;
        end
    end

    // Scan oldest to youngest so the last overlapping match is the youngest.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_idx  = '0;
        ent_word  = 1'b0;
        ld_word   = (ld_size == SZ_WORD);
        if (ld_valid) begin
            for (int i = 0; i < SB_ENTRIES; i++) begin
                scan_idx = head_q + PTR_W'(i);
                ent_word = (size_q[scan_idx] == SZ_WORD);
                if (valid_q[scan_idx] &&
                    addr_q[scan_idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2] &&
                    (ent_word || ld_word || addr_q[scan_idx][1:0] == ld_addr[1:0])) begin
                    sel_found = 1'b1;
                    sel_idx   = scan_idx;
                end
            end
        end
    end

    // Resolve the selected entry into hit data or a stall.
    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        sel_word  = (size_q[sel_idx] == SZ_WORD);
        sel_byte  = value_q[sel_idx][7:0];
        if (sel_word) begin
            case (ld_addr[1:0])
                2'd0:    sel_byte = value_q[sel_idx][7:0];
                2'd1:    sel_byte = value_q[sel_idx][15:8];
                2'd2:    sel_byte = value_q[sel_idx][23:16];
                default: sel_byte = value_q[sel_idx][31:24];
            endcase
        end
        if (sel_found) begin
            if (sel_word || !ld_word) begin
                fwd_hit = 1'b1;
                if (ld_word) fwd_data = value_q[sel_idx];
                else         fwd_data = {{(WORD_SIZE-8){sel_byte[7]}}, sel_byte};
            end else begin
                fwd_stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: FIFO order, backpressure, forwarding, reset.
`ifndef BYTE_SIZE
`define BYTE_SIZE 2'd0
`endif
`ifndef FULL_WORD_SIZE
`define FULL_WORD_SIZE 2'd2
`endif

module tb_store_buffer;
    localparam int N = 4;
    localparam logic [1:0] SZ_B = `BYTE_SIZE;
    localparam logic [1:0] SZ_W = `FULL_WORD_SIZE;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_addr, in_value;
    logic [1:0]  in_size;
    logic        full, empty, wenable;
    logic [31:0] sb_addr, sb_value;
    logic [1:0]  sb_size;
    logic        store_success;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic        fwd_hit, fwd_stall;
    logic [31:0] fwd_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    store_buffer #(.SB_ENTRIES(N), .WORD_SIZE(32), .SIZE_WRITE_WIDTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_addr(in_addr), .in_value(in_value), .in_size(in_size),
        .full(full), .empty(empty),
        .sb_addr(sb_addr), .sb_value(sb_value), .sb_size(sb_size), .wenable(wenable),
        .store_success(store_success),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        in_valid = 0; in_addr = 0; in_value = 0; in_size = 0;
        store_success = 0; ld_valid = 0; ld_addr = 0; ld_size = 0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] v, input logic [1:0] s);
        in_valid = 1; in_addr = a; in_value = v; in_size = s;
        tick();
        in_valid = 0;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] s);
        ld_valid = 1; ld_addr = a; ld_size = s;
        #1;
    endtask

    task automatic drain;
        store_success = 1;
        for (int k = 0; k < 2*N && !empty; k++) tick();
        store_success = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0 || wenable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got empty=%b full=%b wen=%b required 1 0 0", empty, full, wenable);
        end
        n_tests++;
        if (sb_addr !== 0 || sb_value !== 0 || sb_size !== 0) begin
            n_fail++;
            $display("FAIL reset_sb: got %h %h %h required zeros", sb_addr, sb_value, sb_size);
        end
        load(32'h0, SZ_W);
        n_tests++;
        if (fwd_hit !== 0 || fwd_stall !== 0 || fwd_data !== 0) begin
            n_fail++;
            $display("FAIL reset_fwd: got hit=%b stall=%b data=%h required 0 0 0", fwd_hit, fwd_stall, fwd_data);
        end
        ld_valid = 0;
    endtask

    task automatic test_single;
        push(32'h100, 32'hDEADBEEF, SZ_W);
        n_tests++;
        if (wenable !== 1 || empty !== 0 || sb_addr !== 32'h100 || sb_value !== 32'hDEADBEEF || sb_size !== SZ_W) begin
            n_fail++;
            $display("FAIL single_head: got wen=%b empty=%b addr=%h val=%h size=%h required 1 0 100 deadbeef %h",
                     wenable, empty, sb_addr, sb_value, sb_size, SZ_W);
        end
        store_success = 1;
        tick();
        store_success = 0;
        n_tests++;
        if (empty !== 1 || wenable !== 0 || sb_addr !== 0) begin
            n_fail++;
            $display("FAIL single_pop: got empty=%b wen=%b addr=%h required 1 0 0", empty, wenable, sb_addr);
        end
    endtask

    task automatic test_fill;
        for (int k = 0; k < N; k++) push(32'h400 + 32'(4*k), 32'h1111_1111 * (k+1), SZ_W);
        n_tests++;
        if (full !== 1 || empty !== 0) begin
            n_fail++;
            $display("FAIL fill_full: got full=%b empty=%b required 1 0", full, empty);
        end
        push(32'h999C, 32'h55555555, SZ_W);
        n_tests++;
        if (full !== 1 || sb_addr !== 32'h400) begin
            n_fail++;
            $display("FAIL fill_drop: got full=%b head=%h required 1 400", full, sb_addr);
        end
        load(32'h999C, SZ_W);
        n_tests++;
        if (fwd_hit !== 0 || fwd_stall !== 0) begin
            n_fail++;
            $display("FAIL fill_drop_fwd: got hit=%b stall=%b required 0 0", fwd_hit, fwd_stall);
        end
        ld_valid = 0;
        for (int k = 0; k < N; k++) begin
            n_tests++;
            if (sb_addr !== 32'h400 + 32'(4*k) || sb_value !== 32'h1111_1111 * (k+1) || wenable !== 1) begin
                n_fail++;
                $display("FAIL fill_order%0d: got addr=%h val=%h wen=%b required %h %h 1",
                         k, sb_addr, sb_value, wenable, 32'h400 + 32'(4*k), 32'h1111_1111 * (k+1));
            end
            tick();
            n_tests++;
            if (sb_addr !== 32'h400 + 32'(4*k)) begin
                n_fail++;
                $display("FAIL fill_retry%0d: got addr=%h required %h", k, sb_addr, 32'h400 + 32'(4*k));
            end
            store_success = 1;
            tick();
            store_success = 0;
        end
        n_tests++;
        if (empty !== 1 || full !== 0) begin
            n_fail++;
            $display("FAIL fill_drained: got empty=%b full=%b required 1 0", empty, full);
        end
    endtask

    task automatic test_forward;
        push(32'h200, 32'h11223384, SZ_W);
        push(32'h201, 32'h123456AA, SZ_B);
        load(32'h201, SZ_B);
        n_tests++;
        if (fwd_hit !== 1 || fwd_stall !== 0 || fwd_data !== 32'hFFFFFFAA) begin
            n_fail++;
            $display("FAIL fwd_b201: got hit=%b stall=%b data=%h required 1 0 ffffffaa", fwd_hit, fwd_stall, fwd_data);
        end
        load(32'h200, SZ_B);
        n_tests++;
        if (fwd_hit !== 1 || fwd_stall !== 0 || fwd_data !== 32'hFFFFFF84) begin
            n_fail++;
            $display("FAIL fwd_b200: got hit=%b stall=%b data=%h required 1 0 ffffff84", fwd_hit, fwd_stall, fwd_data);
        end
        load(32'h203, SZ_B);
        n_tests++;
        if (fwd_hit !== 1 || fwd_data !== 32'h00000011) begin
            n_fail++;
            $display("FAIL fwd_b203: got hit=%b data=%h required 1 00000011", fwd_hit, fwd_data);
        end
        load(32'h200, SZ_W);
        n_tests++;
        if (fwd_stall !== 1 || fwd_hit !== 0) begin
            n_fail++;
            $display("FAIL fwd_w200_stall: got hit=%b stall=%b required 0 1", fwd_hit, fwd_stall);
        end
        ld_valid = 0;
        #1;
        n_tests++;
        if (fwd_hit !== 0 || fwd_stall !== 0 || fwd_data !== 0) begin
            n_fail++;
            $display("FAIL fwd_ldvalid0: got hit=%b stall=%b data=%h required 0 0 0", fwd_hit, fwd_stall, fwd_data);
        end
        // Same-cycle enqueue must be invisible to the probe.
        in_valid = 1; in_addr = 32'h200; in_value = 32'hCAFEF00D; in_size = SZ_W;
        load(32'h200, SZ_W);
        n_tests++;
        if (fwd_stall !== 1 || fwd_hit !== 0) begin
            n_fail++;
            $display("FAIL fwd_same_cycle: got hit=%b stall=%b required 0 1", fwd_hit, fwd_stall);
        end
        tick();
        in_valid = 0;
        #1;
        n_tests++;
        if (fwd_hit !== 1 || fwd_stall !== 0 || fwd_data !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL fwd_youngest_w: got hit=%b stall=%b data=%h required 1 0 cafef00d", fwd_hit, fwd_stall, fwd_data);
        end
        load(32'h201, SZ_B);
        n_tests++;
        if (fwd_hit !== 1 || fwd_data !== 32'hFFFFFFF0) begin
            n_fail++;
            $display("FAIL fwd_youngest_b: got hit=%b data=%h required 1 fffffff0", fwd_hit, fwd_data);
        end
        ld_valid = 0;
        drain();
    endtask

    task automatic test_no_overlap;
        push(32'h300, 32'h0000007F, SZ_B);
        load(32'h302, SZ_B);
        n_tests++;
        if (fwd_hit !== 0 || fwd_stall !== 0 || fwd_data !== 0) begin
            n_fail++;
            $display("FAIL noovl_b302: got hit=%b stall=%b data=%h required 0 0 0", fwd_hit, fwd_stall, fwd_data);
        end
        load(32'h300, SZ_B);
        n_tests++;
        if (fwd_hit !== 1 || fwd_data !== 32'h0000007F) begin
            n_fail++;
            $display("FAIL noovl_b300: got hit=%b data=%h required 1 0000007f", fwd_hit, fwd_data);
        end
        ld_valid = 0;
        drain();
    endtask

    task automatic test_back_to_back;
        push(32'h600, 32'hA0A0A0A0, SZ_W);
        in_valid = 1; in_addr = 32'h604; in_value = 32'hB1B1B1B1; in_size = SZ_W;
        store_success = 1;
        tick();
        in_valid = 0; store_success = 0;
        n_tests++;
        if (empty !== 0 || full !== 0 || sb_addr !== 32'h604 || sb_value !== 32'hB1B1B1B1) begin
            n_fail++;
            $display("FAIL b2b_head: got empty=%b full=%b addr=%h val=%h required 0 0 604 b1b1b1b1",
                     empty, full, sb_addr, sb_value);
        end
        store_success = 1;
        tick();
        store_success = 0;
        n_tests++;
        if (empty !== 1) begin
            n_fail++;
            $display("FAIL b2b_count1: got empty=%b required 1", empty);
        end
    endtask

    task automatic test_reset_pending;
        push(32'h700, 32'h77777777, SZ_W);
        push(32'h704, 32'h88888888, SZ_W);
        push(32'h708, 32'h99999999, SZ_W);
        rst = 1; store_success = 1;
        in_valid = 1; in_addr = 32'h70C; in_value = 32'h12345678; in_size = SZ_W;
        tick();
        rst = 0; store_success = 0; in_valid = 0;
        load(32'h700, SZ_W);
        n_tests++;
        if (empty !== 1 || wenable !== 0 || full !== 0 || sb_addr !== 0) begin
            n_fail++;
            $display("FAIL rstp_flags: got empty=%b wen=%b full=%b addr=%h required 1 0 0 0",
                     empty, wenable, full, sb_addr);
        end
        n_tests++;
        if (fwd_hit !== 0 || fwd_stall !== 0) begin
            n_fail++;
            $display("FAIL rstp_fwd: got hit=%b stall=%b required 0 0", fwd_hit, fwd_stall);
        end
        ld_valid = 0;
        push(32'h800, 32'h0BADF00D, SZ_W);
        n_tests++;
        if (sb_addr !== 32'h800 || sb_value !== 32'h0BADF00D || wenable !== 1) begin
            n_fail++;
            $display("FAIL rstp_after: got addr=%h val=%h wen=%b required 800 0badf00d 1", sb_addr, sb_value, wenable);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_forward();
        test_no_overlap();
        test_back_to_back();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
